decrypt_pipe_rot: RTL
=====================

Name: decrypt_pipe_rot

Overview:
- Second and third pipeline stages of the Caesar decrypter, directly downstream of the data-compare stage.
- Consumes the compare stage's registered outputs: enable, upper/lower-case flags, and the 32-bit extended word.
- Rotates the letter one-hot right by the programmed key (mod 26), re-encodes it to ASCII with the original case, and passes non-alpha bytes through unchanged.
- Also holds the key register, a processed-character counter and a sticky encoding-error flag.

Parameters:
- CNT_W, 16, width of the saturating character counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en_in  in  1  valid from the compare stage.
- is_alpha_upper_case_in  in  1  upper-case letter flag.
- is_alpha_low_case_in  in  1  lower-case letter flag.
- extended_shift_data_in  in  32  letter: one-hot in [31:6], bit 6+k = letter index k (A/a=0). Non-letter: byte in [7:0], other bits 0.
- key_load  in  1  load key_in into the key register.
- key_in  in  5  decrypt shift amount.
- err_clr  in  1  clear err_sticky.
- en_out  out  1  output byte valid.
- dout  out  8  decrypted ASCII byte.
- key_q  out  5  current key, always 0..25.
- char_count  out  CNT_W  number of valid bytes emitted; saturates at all-ones.
- err_sticky  out  1  encoding error seen since last clear.

Behaviour:
- Reset (rst=1 at posedge): en_out=0, dout=0, key_q=0, char_count=0, err_sticky=0, all internal pipeline registers cleared. Reset mid-stream discards both in-flight bytes; no output is produced for them.
- Key register:
  - On key_load, key_q <= key_in if key_in<26, else key_in-26 (26..31 map to 0..5).
  - A byte accepted in the same cycle as key_load uses the old key; the new key applies from the next cycle.
- Stage R (first register, captured when en_in=1):
  - Letter (exactly one flag set, one-hot valid): register onehot_r = [31:6] rotated right by key_q within 26 bits, i.e. new index = (k - key_q) mod 26. Register the case bit and letter=1.
  - Non-letter (both flags 0): register byte [7:0], letter=0.
  - Error: any flag set with [31:6] not exactly one-hot, or both flags set. Register err=1 and substitute byte 8'h3F.
  - en_r <= en_in every cycle; the data registers update only when en_in=1.
- Stage E (output register):
  - en_out <= en_r.
  - When en_r=1: dout <= letter ? (upper ? 8'h41 : 8'h61) + index(onehot_r) : byte_r.
  - Index encode is a 26-to-5 priority-free encoder; one-hot is guaranteed in this stage.
  - When en_r=0, dout holds its previous value.
- Latency: exactly 2 cycles from en_in to en_out. Throughput 1 byte/cycle, no backpressure; bubbles propagate as en_out=0.
- char_count increments by 1 on each cycle with en_out=1; holds at 2^CNT_W-1.
- err_sticky is set in the cycle an erroneous byte reaches Stage E (en_out=1). err_clr clears it. If set and clear occur in the same cycle, set wins.
- en_in=0 with nonzero data: ignored; no flag or counter change.
- key_q=0: letters pass unchanged. Wrap-around: 'A' with key 1 gives 'Z'.

Test Plan:
- Reset, key_load with key_in=3, then en_in=1, upper=1, data bit 9 ('D') -> two cycles later en_out=1, dout=8'h41 ('A'), char_count=1.
- key=3, lower=1, bit 6 ('a') -> dout=8'h78 ('x') (wrap-around). Then key_in=29 load -> key_q=3.
- Flags 0, data=32'h21 ('!') with key=7 -> dout=8'h21. Back-to-back stream "Khoor" with key 3 over 5 consecutive cycles -> "Hello" on 5 consecutive en_out cycles, char_count=5.
- key_load with key_in=1 in the same cycle as 'B' (bit 7), previous key 0 -> 'B' emitted; a following 'B' -> 'A'.
- upper=1 with data[31:6]=0 -> dout=8'h3F, err_sticky=1. Assert err_clr together with a second error byte reaching the output -> err_sticky stays 1. err_clr alone -> 0.
- Two bytes in flight, rst=1 for one cycle -> no en_out for either byte; all outputs 0 and key_q=0 the cycle after reset.

Source files
------------

// File: rtl/decrypt_pipe_rot.sv
// Caesar decrypter rotate/encode stages: rotates the letter one-hot by the key,
// re-encodes it to ASCII, and tracks key, emitted-byte count and encoding errors.
module decrypt_pipe_rot #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             is_alpha_upper_case_in,
  input  logic             is_alpha_low_case_in,
  input  logic [31:0]      extended_shift_data_in,
  input  logic             key_load,
  input  logic [4:0]       key_in,
  input  logic             err_clr,
  output logic             en_out,
  output logic [7:0]       dout,
  output logic [4:0]       key_q,
  output logic [CNT_W-1:0] char_count,
  output logic             err_sticky
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [7:0]       ErrByte = 8'h3F;

  // Key register
  logic [4:0] key_reg_q, key_reg_d;

  // Stage R registers
  logic        en_r_q, en_r_d;
  logic        letter_r_q, letter_r_d;
  logic        upper_r_q, upper_r_d;
  logic        err_r_q, err_r_d;
  logic [25:0] onehot_r_q, onehot_r_d;
  logic [7:0]  byte_r_q, byte_r_d;

  // Stage E registers and status
  logic             en_out_q, en_out_d;
  logic [7:0]       dout_q, dout_d;
  logic [CNT_W-1:0] char_count_q, char_count_d;
  logic             err_sticky_q, err_sticky_d;

  // Stage R combinational decode
  logic [25:0] letter_bits;
  logic        letter_onehot;
  logic        any_flag;
  logic        in_err;
  logic [51:0] rot_dbl;
  logic [25:0] rot_bits;

  // Stage E index encode
  logic [4:0] letter_idx;

  always_comb begin
    letter_bits   = extended_shift_data_in[31:6];
    letter_onehot = (letter_bits != '0) && ((letter_bits & (letter_bits - 26'd1)) == '0);
    any_flag      = is_alpha_upper_case_in | is_alpha_low_case_in;
    in_err        = any_flag &
                    (~letter_onehot | (is_alpha_upper_case_in & is_alpha_low_case_in));
    // Shifting a doubled copy right yields a 26-bit rotate for key_q in 0..25.
    rot_dbl       = {letter_bits, letter_bits} >> key_reg_q;
    rot_bits      = rot_dbl[25:0];
  end

  always_comb begin
    letter_idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (onehot_r_q[i]) letter_idx = letter_idx | 5'(i);
    end
  end

  always_comb begin
    key_reg_d    = key_reg_q;
    en_r_d       = en_in;
    letter_r_d   = letter_r_q;
    upper_r_d    = upper_r_q;
    err_r_d      = err_r_q;
    onehot_r_d   = onehot_r_q;
    byte_r_d     = byte_r_q;
    en_out_d     = en_r_q;
    dout_d       = dout_q;
    char_count_d = char_count_q;
    err_sticky_d = err_sticky_q & ~err_clr;

    if (key_load) begin
      key_reg_d = (key_in >= 5'd26) ? (key_in - 5'd26) : key_in;
    end

    if (en_in) begin
      letter_r_d = any_flag & ~in_err;
      upper_r_d  = is_alpha_upper_case_in;
      err_r_d    = in_err;
      onehot_r_d = rot_bits;
      byte_r_d   = in_err ? ErrByte : extended_shift_data_in[7:0];
    end

    if (en_r_q) begin
      dout_d = letter_r_q ? ((upper_r_q ? 8'h41 : 8'h61) + {3'b000, letter_idx}) : byte_r_q;
      if (char_count_q != CntMax) char_count_d = char_count_q + CNT_W'(1);
      // Setting wins over a simultaneous clear.
      if (err_r_q) err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg_q    <= '0;
      en_r_q       <= 1'b0;
      letter_r_q   <= 1'b0;
      upper_r_q    <= 1'b0;
      err_r_q      <= 1'b0;
      onehot_r_q   <= '0;
      byte_r_q     <= '0;
      en_out_q     <= 1'b0;
      dout_q       <= '0;
      char_count_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      key_reg_q    <= key_reg_d;
      en_r_q       <= en_r_d;
      letter_r_q   <= letter_r_d;
      upper_r_q    <= upper_r_d;
      err_r_q      <= err_r_d;
      onehot_r_q   <= onehot_r_d;
      byte_r_q     <= byte_r_d;
      en_out_q     <= en_out_d;
      dout_q       <= dout_d;
      char_count_q <= char_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign en_out     = en_out_q;
  assign dout       = dout_q;
  assign key_q      = key_reg_q;
  assign char_count = char_count_q;
  assign err_sticky = err_sticky_q;

endmodule
